scenario_scheduler: RTL and testbench
=====================================

Name: scenario_scheduler

Overview:
- Top-level sequencer for the synchronization block's scenario FSMs (calibration and siblings).
- Accepts run/abort commands and latches the scenario selection and frame count.
- Issues start pulses to the selected scenario FSM, passes its trigger to the single shared output trigger line, and counts frames.
- Watchdogs detector-ready and trigger arrival, and reports busy/done/error status.

Parameters:
NUM_SCEN, 4, number of scenario FSMs sharing the output trigger (2..8)
SEL_W, 3, width of scenario select; must satisfy 2**SEL_W >= NUM_SCEN
FRAME_W, 16, width of frame counters

Ports:
clock  in  1  system clock (200 MHz)
reset_signal  in  1  synchronous, active-low reset
cmd_run  in  1  one-cycle request to start a run
cmd_abort  in  1  one-cycle request to stop immediately
scen_sel  in  SEL_W  scenario index, latched on accepted cmd_run
frame_total  in  FRAME_W  triggers per run, latched; 0 = continuous
timeout_cycles  in  32  watchdog limit in clocks, latched; 0 = disabled
detector_ready  in  1  detector can accept an exposure
scen_trigger  in  NUM_SCEN  output_trigger of each scenario FSM
scen_start  out  NUM_SCEN  one-hot, one-cycle start to selected FSM
trigger_out  out  1  shared output trigger
frames_done  out  FRAME_W  completed triggers in current/last run
busy  out  1  run in progress
done  out  1  one-cycle pulse on normal completion
error  out  1  sticky fault flag
err_code  out  2  0 none, 1 detector timeout, 2 trigger timeout, 3 bad select
sched_state  out  8  encoded current state, for status readout

Behaviour:
- All logic is on the rising edge of clock. reset_signal low at an edge drives every output to 0 and the FSM to IDLE at that edge, including mid-run.
- States and encodings: IDLE=0, ARM=1, START=2, WAIT_TRIG=3, WAIT_TRIG_END=4, CHECK=5, DONE=6, FAULT=7. sched_state carries the encoding.
- IDLE, on cmd_run:
  - Latch scen_sel, frame_total and timeout_cycles.
  - Clear frames_done, error and err_code.
  - If scen_sel >= NUM_SCEN, go to FAULT with err_code=3; otherwise go to ARM.
- ARM: wait for detector_ready=1, then go to START.
- START: assert scen_start[sel] for exactly one cycle, then go to WAIT_TRIG.
- WAIT_TRIG: on scen_trigger[sel]=1, go to WAIT_TRIG_END.
- WAIT_TRIG_END: on scen_trigger[sel]=0, increment frames_done and go to CHECK.
- CHECK:
  - If frame_total != 0 and frames_done == frame_total, go to DONE; otherwise go to ARM.
  - Continuous mode (frame_total=0) loops back to ARM; frames_done wraps from all-ones to 0 silently.
- DONE: done=1 for one cycle, then IDLE.
- FAULT: error=1 and err_code held. Leaves to IDLE on cmd_abort or cmd_run. That cmd_run is consumed and does not start a run.
- busy=1 in every state except IDLE and FAULT.
- trigger_out:
  - Registered copy of scen_trigger[sel], gated to the WAIT_TRIG and WAIT_TRIG_END states; exactly one clock of latency.
  - Non-selected scen_trigger bits never reach trigger_out.
  - A trigger in progress is carried until it falls; the length is set by the scenario FSM.
- Watchdog:
  - A 32-bit counter clears on entry to ARM and on entry to WAIT_TRIG, and increments each cycle in those states.
  - When timeout_cycles != 0 and the counter reaches timeout_cycles:
    - In ARM, go to FAULT with code 1.
    - In WAIT_TRIG, go to FAULT with code 2.
  - No watchdog runs in WAIT_TRIG_END.
- cmd_abort in any busy state goes to IDLE next cycle: trigger_out=0, no done pulse, frames_done retained, no error.
- Priority: reset > cmd_abort > timeout > normal transition.
- cmd_run while busy is ignored.
- cmd_run and cmd_abort together in IDLE: abort wins and no run starts.
- Trigger and timeout in the same cycle: the timeout wins.

Decomposition:
- Add to types_pkg:
  - sched_state_t, an enum with the encodings above.
  - sched_err_t, the 2-bit enum.
  - A TIMEOUT_W=32 constant.
- One sub-module, sched_watchdog: clear, enable and limit in; expired out.
- Scenario selection mux and frame counter stay inline.

Test Plan:
- Nominal: NUM_SCEN=4, sel=1, frame_total=3, detector_ready=1, FSM1 returns a 20-clock trigger 50 clocks after each start.
  - Expect three scen_start[1] pulses and three 20-clock trigger_out pulses, each delayed 1 clock.
  - Then frames_done=3 and a single done pulse; busy falls with DONE.
- Detector timeout: timeout_cycles=1000, detector_ready=0.
  - FAULT entered exactly 1000 clocks after ARM entry; err_code=1, error=1, no scen_start.
  - cmd_abort then returns to IDLE with error cleared on the next cmd_run.
- Isolation/trigger timeout: sel=2, only scen_trigger[0] toggles, timeout=500.
  - trigger_out stays 0; FAULT with err_code=2, 500 clocks after START.
- Bad select: scen_sel=5 with NUM_SCEN=4.
  - FAULT with err_code=3 one clock after cmd_run; no scen_start.
- Abort and reset mid-run:
  - cmd_abort during WAIT_TRIG_END: trigger_out drops the next clock, frames_done unchanged, no done.
  - reset_signal=0 mid-run: all outputs are 0 at that edge.
- Continuous mode: frame_total=0, FRAME_W=4.
  - After 17 triggers frames_done=1, no done pulse, busy stays 1.
  - cmd_run during the run is ignored.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the scenario scheduler.
// Holds the FSM state encoding, error codes and watchdog width.
package types_pkg;

    localparam int TIMEOUT_W = 32;

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_ARM           = 3'd1,
        S_START         = 3'd2,
        S_WAIT_TRIG     = 3'd3,
        S_WAIT_TRIG_END = 3'd4,
        S_CHECK         = 3'd5,
        S_DONE          = 3'd6,
        S_FAULT         = 3'd7
    } sched_state_t;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_DET_TIMEOUT  = 2'd1,
        ERR_TRIG_TIMEOUT = 2'd2,
        ERR_BAD_SEL      = 2'd3
    } sched_err_t;

endpackage

// File: rtl/sched_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the count would reach the limit (limit 0 disables).
module sched_watchdog
    import types_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic [TIMEOUT_W-1:0] limit_i,
    output logic                 expired_o
);

    logic [TIMEOUT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flagging at limit-1 makes the owning FSM leave exactly limit clocks after entry.
    assign expired_o = enable_i && (limit_i != '0) && (count_q == limit_i - 1'b1);

endmodule

// File: rtl/scenario_scheduler.sv
// Top-level sequencer: starts the selected scenario FSM, forwards its trigger
// to the shared output line, counts frames and watches for stalls.
module scenario_scheduler
    import types_pkg::*;
#(
    parameter int NUM_SCEN = 4,
    parameter int SEL_W    = 3,
    parameter int FRAME_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset_signal,
    input  logic                 cmd_run,
    input  logic                 cmd_abort,
    input  logic [SEL_W-1:0]     scen_sel,
    input  logic [FRAME_W-1:0]   frame_total,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic                 detector_ready,
    input  logic [NUM_SCEN-1:0]  scen_trigger,
    output logic [NUM_SCEN-1:0]  scen_start,
    output logic                 trigger_out,
    output logic [FRAME_W-1:0]   frames_done,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [7:0]           sched_state
);

    sched_state_t         state_q, state_d;
    sched_err_t           err_code_q, err_code_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [FRAME_W-1:0]   total_q, total_d;
    logic [FRAME_W-1:0]   frames_q, frames_d;
    logic [TIMEOUT_W-1:0] limit_q, limit_d;
    logic                 error_q, error_d;
    logic                 trig_out_q, trig_out_d;

    logic [NUM_SCEN-1:0]  sel_onehot;
    logic                 trig_sel;
    logic                 busy_state;
    logic                 wd_clear, wd_enable, wd_expired;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SCEN; gi++) begin : g_sel
            assign sel_onehot[gi] = (sel_q == SEL_W'(gi));
        end
    endgenerate

    // Only the latched scenario's trigger is ever observed.
    assign trig_sel   = |(scen_trigger & sel_onehot);
    assign busy_state = (state_q != S_IDLE) && (state_q != S_FAULT);

    assign wd_enable = (state_q == S_ARM) || (state_q == S_WAIT_TRIG);
    assign wd_clear  = ((state_d == S_ARM)       && (state_q != S_ARM)) ||
                       ((state_d == S_WAIT_TRIG) && (state_q != S_WAIT_TRIG));

    sched_watchdog u_watchdog (
        .clk_i     (clock),
        .rst_ni    (reset_signal),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .limit_i   (limit_q),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        total_d    = total_q;
        limit_d    = limit_q;
        frames_d   = frames_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        trig_out_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_run && !cmd_abort) begin
                    sel_d      = scen_sel;
                    total_d    = frame_total;
                    limit_d    = timeout_cycles;
                    frames_d   = '0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    if (32'(scen_sel) >= NUM_SCEN) begin
                        state_d    = S_FAULT;
                        error_d    = 1'b1;
                        err_code_d = ERR_BAD_SEL;
                    end else begin
                        state_d = S_ARM;
                    end
                end
            end
            S_ARM: begin
                if (wd_expired) begin
                    state_d    = S_FAULT;
                    error_d    = 1'b1;
                    err_code_d = ERR_DET_TIMEOUT;
                end else if (detector_ready) begin
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT_TRIG;
            S_WAIT_TRIG: begin
                // A trigger arriving on the expiry cycle loses to the timeout.
                if (wd_expired) begin
                    state_d    = S_FAULT;
                    error_d    = 1'b1;
                    err_code_d = ERR_TRIG_TIMEOUT;
                end else if (trig_sel) begin
                    state_d    = S_WAIT_TRIG_END;
                    trig_out_d = 1'b1;
                end
            end
            S_WAIT_TRIG_END: begin
                if (trig_sel) begin
                    trig_out_d = 1'b1;
                end else begin
                    frames_d = frames_q + 1'b1;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((total_q != '0) && (frames_q == total_q)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_FAULT: begin
                if (cmd_abort || cmd_run) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort discards whatever the current state decided, keeping counters and status.
        if (cmd_abort && busy_state) begin
            state_d    = S_IDLE;
            trig_out_d = 1'b0;
            frames_d   = frames_q;
            error_d    = error_q;
            err_code_d = err_code_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            total_q    <= '0;
            limit_q    <= '0;
            frames_q   <= '0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            trig_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            total_q    <= total_d;
            limit_q    <= limit_d;
            frames_q   <= frames_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            trig_out_q <= trig_out_d;
        end
    end

    assign scen_start  = (state_q == S_START) ? sel_onehot : '0;
    assign trigger_out = trig_out_q;
    assign frames_done = frames_q;
    assign busy        = busy_state;
    assign done        = (state_q == S_DONE);
    assign error       = error_q;
    assign err_code    = err_code_q;
    assign sched_state = {5'd0, state_q};

endmodule

// File: tb/tb_scenario_scheduler.sv
// Directed bench for scenario_scheduler: a behavioural scenario FSM on index 1
// answers start pulses; a negedge monitor tallies pulses for the checks.
module tb_scenario_scheduler;

    logic        clock = 1'b0;
    logic        reset_signal = 1'b0;
    logic        cmd_run = 1'b0;
    logic        cmd_abort = 1'b0;
    logic [2:0]  scen_sel = '0;
    logic [3:0]  frame_total = '0;
    logic [31:0] timeout_cycles = '0;
    logic        detector_ready = 1'b0;
    logic [3:0]  scen_trigger;
    logic [3:0]  scen_start;
    logic        trigger_out;
    logic [3:0]  frames_done;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [7:0]  sched_state;

    logic [3:0]  manual_trig = '0;
    logic        resp_trig = 1'b0;
    logic        resp_en = 1'b0;
    int          resp_delay = 50;
    int          resp_len = 20;

    assign scen_trigger = manual_trig | {2'b00, resp_trig, 1'b0};

    scenario_scheduler #(
        .NUM_SCEN (4),
        .SEL_W    (3),
        .FRAME_W  (4)
    ) dut (
        .clock          (clock),
        .reset_signal   (reset_signal),
        .cmd_run        (cmd_run),
        .cmd_abort      (cmd_abort),
        .scen_sel       (scen_sel),
        .frame_total    (frame_total),
        .timeout_cycles (timeout_cycles),
        .detector_ready (detector_ready),
        .scen_trigger   (scen_trigger),
        .scen_start     (scen_start),
        .trigger_out    (trigger_out),
        .frames_done    (frames_done),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .err_code       (err_code),
        .sched_state    (sched_state)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Scenario FSM 1 model: trigger of resp_len clocks, resp_delay clocks after its start.
    int   resp_cnt = 0;
    int   resp_rise_cyc = 0;
    logic resp_on = 1'b0;
    always @(negedge clock) begin
        if (resp_en && scen_start[1]) begin
            resp_on  = 1'b1;
            resp_cnt = 0;
        end else if (resp_on) begin
            resp_cnt++;
            if (resp_cnt == resp_delay) begin
                resp_trig     = 1'b1;
                resp_rise_cyc = cyc;
            end
            if (resp_cnt == resp_delay + resp_len) begin
                resp_trig = 1'b0;
                resp_on   = 1'b0;
            end
        end
    end

    int   start_cnt [4] = '{default: 0};
    int   done_cnt = 0;
    int   tout_rise = 0;
    int   dly_ok = 0;
    int   len20 = 0;
    int   tout_len = 0;
    logic tout_prev = 1'b0;
    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) if (scen_start[i]) start_cnt[i]++;
        if (done) done_cnt++;
        if (trigger_out) tout_len++;
        if (trigger_out && !tout_prev) begin
            tout_rise++;
            if (cyc - resp_rise_cyc == 1) dly_ok++;
        end
        if (!trigger_out && tout_prev) begin
            if (tout_len == 20) len20++;
            tout_len = 0;
        end
        tout_prev = trigger_out;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic run_cmd(input logic [2:0] sel, input logic [3:0] tot, input logic [31:0] tmo);
        scen_sel       = sel;
        frame_total    = tot;
        timeout_cycles = tmo;
        cmd_run        = 1'b1;
        tick();
        cmd_run = 1'b0;
        $display("run sel=%0d total=%0d timeout=%0d -> state=%0d", sel, tot, tmo, sched_state);
    endtask

    task automatic abort_cmd();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        $display("abort -> state=%0d frames=%0d", sched_state, frames_done);
    endtask

    int b_start0, b_start1, b_start2, b_start3, b_done, b_rise, b_dly, b_len;
    int t0, w0;

    task automatic snap();
        b_start0 = start_cnt[0];
        b_start1 = start_cnt[1];
        b_start2 = start_cnt[2];
        b_start3 = start_cnt[3];
        b_done   = done_cnt;
        b_rise   = tout_rise;
        b_dly    = dly_ok;
        b_len    = len20;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        repeat (3) tick();
        check_eq("rst_state", 32'(sched_state), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_outs", 32'({scen_start, trigger_out, frames_done, done, error, err_code}), 0);
        reset_signal = 1'b1;
        tick();

        // Nominal: three frames, 20-clock triggers 50 clocks after each start.
        detector_ready = 1'b1;
        resp_en = 1'b1; resp_delay = 50; resp_len = 20;
        snap();
        run_cmd(3'd1, 4'd3, 32'd0);
        check_eq("nom_arm", 32'(sched_state), 1);
        for (int i = 0; i < 600 && !done; i++) tick();
        check_eq("nom_done_seen", 32'(done), 1);
        check_eq("nom_busy_in_done", 32'(busy), 1);
        check_eq("nom_frames", 32'(frames_done), 3);
        tick();
        check_eq("nom_busy_after", 32'(busy), 0);
        check_eq("nom_idle", 32'(sched_state), 0);
        check_eq("nom_starts1", 32'(start_cnt[1] - b_start1), 3);
        check_eq("nom_starts_other", 32'((start_cnt[0] - b_start0) + (start_cnt[2] - b_start2) + (start_cnt[3] - b_start3)), 0);
        check_eq("nom_tout_pulses", 32'(tout_rise - b_rise), 3);
        check_eq("nom_tout_delay1", 32'(dly_ok - b_dly), 3);
        check_eq("nom_tout_len20", 32'(len20 - b_len), 3);
        check_eq("nom_done_count", 32'(done_cnt - b_done), 1);

        // Detector timeout: FAULT exactly 1000 clocks after ARM entry.
        detector_ready = 1'b0;
        resp_en = 1'b0;
        snap();
        run_cmd(3'd0, 4'd1, 32'd1000);
        check_eq("det_arm", 32'(sched_state), 1);
        t0 = cyc;
        for (int i = 0; i < 1100 && sched_state == 8'd1; i++) tick();
        check_eq("det_state", 32'(sched_state), 7);
        check_eq("det_latency", 32'(cyc - t0), 1000);
        check_eq("det_code", 32'(err_code), 1);
        check_eq("det_error", 32'(error), 1);
        check_eq("det_busy", 32'(busy), 0);
        check_eq("det_no_start", 32'((start_cnt[0] - b_start0) + (start_cnt[1] - b_start1)), 0);
        abort_cmd();
        check_eq("det_abort_idle", 32'(sched_state), 0);
        check_eq("det_error_sticky", 32'(error), 1);
        detector_ready = 1'b1;
        run_cmd(3'd0, 4'd1, 32'd0);
        check_eq("det_rerun_err_clr", 32'({error, err_code}), 0);
        check_eq("det_rerun_arm", 32'(sched_state), 1);
        abort_cmd();
        check_eq("arm_abort_idle", 32'(sched_state), 0);
        check_eq("arm_abort_no_err", 32'(error), 0);

        // Isolation: scenario 2 selected, only scenario 0 toggles.
        snap();
        w0 = -1;
        run_cmd(3'd2, 4'd1, 32'd500);
        for (int i = 0; i < 700 && sched_state != 8'd7; i++) begin
            manual_trig[0] = ~manual_trig[0];
            tick();
            if (sched_state == 8'd3 && w0 < 0) w0 = cyc;
        end
        manual_trig = '0;
        check_eq("iso_state", 32'(sched_state), 7);
        check_eq("iso_code", 32'(err_code), 2);
        check_eq("iso_latency", 32'(cyc - w0), 500);
        check_eq("iso_no_tout", 32'(tout_rise - b_rise), 0);
        check_eq("iso_start2", 32'(start_cnt[2] - b_start2), 1);
        abort_cmd();

        // Bad select, then a cmd_run in FAULT is consumed without starting.
        snap();
        run_cmd(3'd5, 4'd1, 32'd0);
        check_eq("bad_state", 32'(sched_state), 7);
        check_eq("bad_code", 32'(err_code), 3);
        run_cmd(3'd1, 4'd1, 32'd0);
        check_eq("bad_run_consumed", 32'(sched_state), 0);
        repeat (3) tick();
        check_eq("bad_stays_idle", 32'(sched_state), 0);
        check_eq("bad_no_start", 32'((start_cnt[0] - b_start0) + (start_cnt[1] - b_start1) + (start_cnt[2] - b_start2) + (start_cnt[3] - b_start3)), 0);

        // Abort during the second frame's WAIT_TRIG_END.
        resp_en = 1'b1;
        snap();
        run_cmd(3'd1, 4'd3, 32'd0);
        for (int i = 0; i < 400 && !(frames_done == 4'd1 && sched_state == 8'd4); i++) tick();
        repeat (2) tick();
        check_eq("abt_pre_state", 32'(sched_state), 4);
        check_eq("abt_pre_tout", 32'(trigger_out), 1);
        abort_cmd();
        check_eq("abt_tout_drop", 32'(trigger_out), 0);
        check_eq("abt_idle", 32'(sched_state), 0);
        check_eq("abt_frames_kept", 32'(frames_done), 1);
        check_eq("abt_no_err", 32'(error), 0);
        repeat (80) tick();
        check_eq("abt_no_done", 32'(done_cnt - b_done), 0);

        // Reset mid-run clears every output at that edge.
        run_cmd(3'd1, 4'd3, 32'd0);
        for (int i = 0; i < 400 && !(frames_done == 4'd1 && sched_state == 8'd4); i++) tick();
        check_eq("rmid_pre_frames", 32'(frames_done), 1);
        reset_signal = 1'b0;
        tick();
        check_eq("rmid_all_zero", 32'({sched_state, scen_start, trigger_out, frames_done, busy, done, error, err_code}), 0);
        reset_signal = 1'b1;
        repeat (80) tick();

        // Continuous mode: 17 short triggers wrap the 4-bit frame counter to 1.
        resp_delay = 3; resp_len = 2;
        snap();
        run_cmd(3'd1, 4'd0, 32'd0);
        repeat (20) tick();
        run_cmd(3'd3, 4'd1, 32'd0);
        for (int i = 0; i < 1000 && !((tout_rise - b_rise) == 17 && !trigger_out); i++) tick();
        check_eq("cont_pulses", 32'(tout_rise - b_rise), 17);
        check_eq("cont_frames_wrap", 32'(frames_done), 1);
        check_eq("cont_busy", 32'(busy), 1);
        check_eq("cont_no_done", 32'(done_cnt - b_done), 0);
        check_eq("cont_starts1", 32'(start_cnt[1] - b_start1), 17);
        check_eq("cont_run_ignored", 32'(start_cnt[3] - b_start3), 0);
        abort_cmd();
        check_eq("cont_abort_idle", 32'(sched_state), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
